// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM states and address limit for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned ADDR_LIMIT_DEFAULT = 65532;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request, response and dataMemory signals of the load/store unit
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_store;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_read;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_read, mem_write, mem_wdata
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load lane extract/extend and sub-word store merge
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = word[{offset, 3'b000} +: 8];
    half_sel   = offset[1] ? word[31:16] : word[15:0];
    load_data  = word;
    merge_data = wdata;

    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = word;
    endcase

    // Word stores pass wdata through untouched; sub-word stores patch the old word.
    case (funct3)
      F3_B: begin
        merge_data = word;
        merge_data[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      F3_H: begin
        merge_data = word;
        if (offset[1]) merge_data[31:16] = wdata[15:0];
        else           merge_data[15:0]  = wdata[15:0];
      end
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage front end: checks requests, issues word accesses, RMW for SB/SH
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int unsigned ADDR_LIMIT = ADDR_LIMIT_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);

  lsu_state_t            state_q, state_d;
  logic                  store_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] merge_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic                  resp_err_q;

  logic                  req_err;
  logic [ADDR_WIDTH-1:0] req_word_addr;
  logic [DATA_WIDTH-1:0] align_word;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merge_data;

  assign req_word_addr = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    req_err = 1'b0;
    case (bus.req_funct3)
      F3_B:    req_err = 1'b0;
      F3_H:    req_err = bus.req_addr[0];
      F3_W:    req_err = |bus.req_addr[1:0];
      F3_BU:   req_err = bus.req_store;
      F3_HU:   req_err = bus.req_store | bus.req_addr[0];
      default: req_err = 1'b1;
    endcase
    if (req_word_addr >= ADDR_WIDTH'(ADDR_LIMIT)) req_err = 1'b1;
  end

  // In WR the aligner merges into the saved old word; in RD it extracts from live memory data.
  assign align_word = (state_q == WR) ? merge_q : bus.mem_rdata;

  lsu_align u_align (
    .word       (align_word),
    .funct3     (funct3_q),
    .offset     (addr_q[1:0]),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_err)                      state_d = RESP;
          else if (!bus.req_store)          state_d = RD;
          else if (bus.req_funct3 == F3_W)  state_d = WR;
          else                              state_d = RD;
        end
      end
      RD:      state_d = store_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == RESP);
    bus.resp_rdata = resp_rdata_q;
    bus.resp_err   = resp_err_q;
    bus.mem_read   = (state_q == RD);
    bus.mem_write  = (state_q == WR);
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    if (state_q == RD || state_q == WR) bus.mem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    if (state_q == WR)                  bus.mem_wdata = merge_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      store_q      <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      merge_q      <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            store_q      <= bus.req_store;
            funct3_q     <= bus.req_funct3;
            addr_q       <= bus.req_addr;
            wdata_q      <= bus.req_wdata;
            resp_rdata_q <= '0;
            resp_err_q   <= req_err;
          end
        end
        RD: begin
          if (store_q) merge_q      <= bus.mem_rdata;
          else         resp_rdata_q <= load_data;
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench: directed vectors, corner sequences, randomized model comparison
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem     [0:16383];
  logic [31:0] ref_mem [0:16383];
  logic        pre_en = 1'b0;
  logic [13:0] pre_idx = '0;
  logic [31:0] pre_data = '0;

  assign bus.mem_rdata = mem[bus.mem_addr[15:2]];

  always @(posedge clk) begin
    if (bus.mem_write)  mem[bus.mem_addr[15:2]] <= bus.mem_wdata;
    else if (pre_en)    mem[pre_idx] <= pre_data;
  end

  int rd_cnt = 0;
  int wr_cnt = 0;
  int proto_err = 0;

  always @(negedge clk) begin
    if (bus.mem_read)  rd_cnt++;
    if (bus.mem_write) wr_cnt++;
    if (bus.mem_read && bus.mem_write) proto_err++;
    if (!bus.mem_read && !bus.mem_write && (bus.mem_addr != 0 || bus.mem_wdata != 0)) proto_err++;
    if (bus.mem_addr[1:0] != 2'b00) proto_err++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string name);
    chk({name, "/req_ready"},  32'(bus.req_ready), 1);
    chk({name, "/resp_valid"}, 32'(bus.resp_valid), 0);
    chk({name, "/resp_rdata"}, bus.resp_rdata, 0);
    chk({name, "/resp_err"},   32'(bus.resp_err), 0);
    chk({name, "/mem_read"},   32'(bus.mem_read), 0);
    chk({name, "/mem_write"},  32'(bus.mem_write), 0);
    chk({name, "/mem_addr"},   bus.mem_addr, 0);
    chk({name, "/mem_wdata"},  bus.mem_wdata, 0);
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    @(negedge clk);
    pre_en   = 1'b1;
    pre_idx  = idx[13:0];
    pre_data = d;
    ref_mem[idx] = d;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  // Reference behaviour from the architectural rules: access size, alignment, range, extension.
  function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic err, output logic [31:0] rd,
                                output int lat, output int nr, output int nw);
    int          size;
    int          off;
    int          idx;
    logic        legal;
    logic [31:0] word, mask, v;
    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5) && !(st && f3 >= 3'd4);
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    err   = !legal || ((a % size) != 0) || ((a & ~32'd3) >= 32'd65532);
    rd = 0; lat = 1; nr = 0; nw = 0;
    if (err) return;
    off  = int'(a % 4);
    idx  = int'(a >> 2);
    word = ref_mem[idx];
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 1);
    if (!st) begin
      v = (word >> (8 * off)) & mask;
      if (f3 < 3'd4 && v[8 * size - 1]) v = v | ~mask;
      rd = v; lat = 2; nr = 1;
    end else begin
      mask = mask << (8 * off);
      ref_mem[idx] = (word & ~mask) | ((wd << (8 * off)) & mask);
      lat = (size == 4) ? 2 : 3;
      nr  = (size == 4) ? 0 : 1;
      nw  = 1;
    end
  endfunction

  task automatic run_txn(input string name, input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int hold, input logic e_err,
                         input logic [31:0] e_rd, input int e_lat, input int e_nr, input int e_nw);
    int          r0, w0, lat;
    logic        stable;
    logic [31:0] d0;
    logic        er0;
    @(negedge clk);
    chk({name, "/ready_before"}, 32'(bus.req_ready), 1);
    r0 = rd_cnt;
    w0 = wr_cnt;
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.resp_valid && lat < 20);
    if (!bus.resp_valid) begin
      chk({name, "/resp_timeout"}, 0, 1);
      return;
    end
    chk({name, "/latency"}, lat, e_lat);
    chk({name, "/err"},     32'(bus.resp_err), 32'(e_err));
    chk({name, "/rdata"},   bus.resp_rdata, e_rd);
    chk({name, "/reads"},   rd_cnt - r0, e_nr);
    chk({name, "/writes"},  wr_cnt - w0, e_nw);
    d0 = bus.resp_rdata;
    er0 = bus.resp_err;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!bus.resp_valid || bus.resp_rdata !== d0 || bus.resp_err !== er0 || bus.req_ready) stable = 1'b0;
    end
    if (hold > 0) chk({name, "/hold_stable"}, 32'(stable), 1);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    @(negedge clk);
    chk({name, "/ready_after"}, 32'(bus.req_ready), 1);
    chk({name, "/valid_after"}, 32'(bus.resp_valid), 0);
  endtask

  typedef struct {
    logic        pre;
    logic [31:0] pre_word;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        e_err;
    logic [31:0] e_rd;
    int          e_lat;
    int          e_nr;
    int          e_nw;
    logic [31:0] e_word;
  } vec_t;

  vec_t vt [19];

  logic [2:0] f3_pool [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd7};

  initial begin
    logic        m_err;
    logic [31:0] m_rd;
    int          m_lat, m_nr, m_nw, w0, mism;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a, wd;

    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 256; i++) preload(i, $urandom);
    for (int i = 16380; i < 16383; i++) preload(i, $urandom);

    vt[0]  = '{1'b1, 32'hDEADBEEF, 1'b0, F3_W,   32'h100,  32'h0,        1'b0, 32'hDEADBEEF, 2, 1, 0, 32'hDEADBEEF};
    vt[1]  = '{1'b0, 32'h0,        1'b0, F3_B,   32'h103,  32'h0,        1'b0, 32'hFFFFFFDE, 2, 1, 0, 32'hDEADBEEF};
    vt[2]  = '{1'b0, 32'h0,        1'b0, F3_BU,  32'h103,  32'h0,        1'b0, 32'h000000DE, 2, 1, 0, 32'hDEADBEEF};
    vt[3]  = '{1'b0, 32'h0,        1'b0, F3_H,   32'h102,  32'h0,        1'b0, 32'hFFFFDEAD, 2, 1, 0, 32'hDEADBEEF};
    vt[4]  = '{1'b1, 32'h11223344, 1'b1, F3_B,   32'h101,  32'hAABBCC55, 1'b0, 32'h0,        3, 1, 1, 32'h11225544};
    vt[5]  = '{1'b0, 32'h0,        1'b0, F3_W,   32'h100,  32'h0,        1'b0, 32'h11225544, 2, 1, 0, 32'h11225544};
    vt[6]  = '{1'b0, 32'h0,        1'b0, F3_W,   32'h102,  32'h0,        1'b1, 32'h0,        1, 0, 0, 32'h11225544};
    vt[7]  = '{1'b0, 32'h0,        1'b1, F3_H,   32'h103,  32'h1234,     1'b1, 32'h0,        1, 0, 0, 32'h11225544};
    vt[8]  = '{1'b0, 32'h0,        1'b0, F3_W,   32'hFFFC, 32'h0,        1'b1, 32'h0,        1, 0, 0, 32'h0};
    vt[9]  = '{1'b1, 32'h12345678, 1'b1, F3_H,   32'h202,  32'hFFFFBEEF, 1'b0, 32'h0,        3, 1, 1, 32'hBEEF5678};
    vt[10] = '{1'b1, 32'h12348001, 1'b0, F3_HU,  32'h204,  32'h0,        1'b0, 32'h00008001, 2, 1, 0, 32'h12348001};
    vt[11] = '{1'b0, 32'h0,        1'b0, F3_H,   32'h204,  32'h0,        1'b0, 32'hFFFF8001, 2, 1, 0, 32'h12348001};
    vt[12] = '{1'b0, 32'h0,        1'b1, F3_BU,  32'h204,  32'hFF,       1'b1, 32'h0,        1, 0, 0, 32'h12348001};
    vt[13] = '{1'b0, 32'h0,        1'b0, 3'b011, 32'h204,  32'h0,        1'b1, 32'h0,        1, 0, 0, 32'h12348001};
    vt[14] = '{1'b1, 32'h0,        1'b1, F3_W,   32'h300,  32'hCAFEF00D, 1'b0, 32'h0,        2, 0, 1, 32'hCAFEF00D};
    vt[15] = '{1'b1, 32'h80112233, 1'b0, F3_B,   32'hFFFB, 32'h0,        1'b0, 32'hFFFFFF80, 2, 1, 0, 32'h80112233};
    vt[16] = '{1'b0, 32'h0,        1'b0, F3_B,   32'hFFFC, 32'h0,        1'b1, 32'h0,        1, 0, 0, 32'h0};
    vt[17] = '{1'b0, 32'h0,        1'b0, F3_HU,  32'h206,  32'h0,        1'b0, 32'h00001234, 2, 1, 0, 32'h12348001};
    vt[18] = '{1'b0, 32'h0,        1'b1, F3_B,   32'h203,  32'h77,       1'b0, 32'h0,        3, 1, 1, 32'h77EF5678};

    for (int i = 0; i < 19; i++) begin
      if (vt[i].pre) preload(int'(vt[i].addr >> 2), vt[i].pre_word);
      run_txn($sformatf("vec%0d", i), vt[i].st, vt[i].f3, vt[i].addr, vt[i].wd, 0,
              vt[i].e_err, vt[i].e_rd, vt[i].e_lat, vt[i].e_nr, vt[i].e_nw);
      model(vt[i].st, vt[i].f3, vt[i].addr, vt[i].wd, m_err, m_rd, m_lat, m_nr, m_nw);
      if (vt[i].addr < 32'd65532) chk($sformatf("vec%0d/word", i), mem[vt[i].addr[15:2]], vt[i].e_word);
    end

    // Response held off by writeback for five cycles.
    model(1'b0, F3_W, 32'h100, 32'h0, m_err, m_rd, m_lat, m_nr, m_nw);
    run_txn("hold5", 1'b0, F3_W, 32'h100, 32'h0, 5, m_err, m_rd, m_lat, m_nr, m_nw);

    // Reset during the read half of a byte store must cancel the write.
    preload(256, 32'hA5A5A5A5);
    @(negedge clk);
    w0 = wr_cnt;
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b1;
    bus.req_funct3 = F3_B;
    bus.req_addr   = 32'h401;
    bus.req_wdata  = 32'h3C;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rst_rd/in_rd", 32'(bus.mem_read), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset("rst_rd");
    repeat (3) @(negedge clk);
    chk("rst_rd/no_write", wr_cnt - w0, 0);
    chk("rst_rd/word", mem[256], 32'hA5A5A5A5);

    for (int n = 0; n < 60; n++) begin
      int r;
      st = 1'($urandom_range(0, 1));
      f3 = f3_pool[$urandom_range(0, 9)];
      wd = $urandom;
      r  = $urandom_range(0, 9);
      if (r == 0)      a = 32'hFFF0 + $urandom_range(0, 15);
      else if (r == 1) a = $urandom | 32'h0001_0000;
      else             a = $urandom_range(0, 1023);
      model(st, f3, a, wd, m_err, m_rd, m_lat, m_nr, m_nw);
      run_txn($sformatf("rnd%0d", n), st, f3, a, wd, 0, m_err, m_rd, m_lat, m_nr, m_nw);
    end

    mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
    for (int i = 16380; i < 16383; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk("mem_image", mism, 0);
    chk("protocol", proto_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
